// File: rtl/multi_arbiter.sv
// ============================================================================
// Module      : multi_arbiter
// Description : Two-requester arbiter with a two-stage pipeline in front of a
//               shared combinational multi unit. The response channel carries
//               the owning requester's index. Round-robin grant is compiled in
//               with MULTI_ARB_RR_EN; without it, requester 0 has priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_arbiter #(
  parameter int REG_W = 8,
  parameter int IMM_W = 5
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [REG_W-1:0] req_reg0,
  input  logic [IMM_W-1:0] req_imm0,
  input  logic [REG_W-1:0] req_reg1,
  input  logic [IMM_W-1:0] req_imm1,
  output logic [REG_W-1:0] mul_register,
  output logic [IMM_W-1:0] mul_immediate,
  input  logic [REG_W-1:0] mul_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [REG_W-1:0] resp_data,
  output logic             resp_id
);

  logic r_s1_valid;
  logic r_s1_id;
  logic w_s2_free;
  logic w_s1_free;
  logic w_gnt;
  logic w_accept;

  assign w_s2_free = !resp_valid | resp_ready;
  assign w_s1_free = !r_s1_valid | w_s2_free;

`ifdef MULTI_ARB_RR_EN
  logic r_last;

  // On contention the requester that did not win last time goes next.
  assign w_gnt = (req_valid == 2'b11) ? ~r_last : req_valid[1];
`else
  assign w_gnt = req_valid[1] & ~req_valid[0];
`endif

  always_comb begin
    req_ready = 2'b00;
    if (w_s1_free && n_reset && req_valid[w_gnt])
      req_ready[w_gnt] = 1'b1;
  end

  assign w_accept = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_id       <= 1'b0;
      mul_register  <= '0;
      mul_immediate <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_id       <= 1'b0;
`ifdef MULTI_ARB_RR_EN
      r_last        <= 1'b1;
`endif
    end else begin
      // Stage 2: capture the shared unit's output, or retire the response.
      if (r_s1_valid && w_s2_free) begin
        resp_data  <= mul_result;
        resp_id    <= r_s1_id;
        resp_valid <= 1'b1;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end

      // Stage 1: operands stay put when not loading so the unit output is stable.
      if (w_accept) begin
        mul_register  <= w_gnt ? req_reg1 : req_reg0;
        mul_immediate <= w_gnt ? req_imm1 : req_imm0;
        r_s1_id       <= w_gnt;
        r_s1_valid    <= 1'b1;
`ifdef MULTI_ARB_RR_EN
        r_last        <= w_gnt;
`endif
      end else if (w_s2_free) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_arbiter.sv
// ============================================================================
// Module      : tb_multi_arbiter
// Description : Directed self-checking bench for multi_arbiter, with a
//               behavioural model of the shared multi unit on the mul_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_arbiter;

  localparam int REG_W = 8;
  localparam int IMM_W = 5;

  logic             clk;
  logic             n_reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [REG_W-1:0] req_reg0;
  logic [IMM_W-1:0] req_imm0;
  logic [REG_W-1:0] req_reg1;
  logic [IMM_W-1:0] req_imm1;
  logic [REG_W-1:0] mul_register;
  logic [IMM_W-1:0] mul_immediate;
  logic [REG_W-1:0] mul_result;
  logic             resp_valid;
  logic             resp_ready;
  logic [REG_W-1:0] resp_data;
  logic             resp_id;

  int n_tests = 0;
  int n_fail  = 0;

  multi_arbiter #(.REG_W(REG_W), .IMM_W(IMM_W)) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_reg0      (req_reg0),
    .req_imm0      (req_imm0),
    .req_reg1      (req_reg1),
    .req_imm1      (req_imm1),
    .mul_register  (mul_register),
    .mul_immediate (mul_immediate),
    .mul_result    (mul_result),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_id       (resp_id)
  );

  // Shared multi unit: (reg * imm) >>> 3, truncated to REG_W.
  logic signed [REG_W+IMM_W-1:0] w_prod;
  assign w_prod     = $signed(mul_register) * $signed(mul_immediate);
  assign mul_result = w_prod[REG_W+2:3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_gnt [4];

  initial begin
    n_reset    = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    req_reg0 = '0; req_imm0 = '0; req_reg1 = '0; req_imm1 = '0;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rvalid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", 32'(resp_data), 32'h0);
    chk("rst_mreg", 32'(mul_register), 32'h0);
    chk("rst_mimm", 32'(mul_immediate), 32'h0);
    tick();
    n_reset   = 1'b1;
    req_valid = 2'b00;
    tick();

    // Single request from requester 0: 6*6>>>3 = 4
    req_valid = 2'b01; req_reg0 = 8'h06; req_imm0 = 5'h06;
    @(negedge clk); chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_lat_rvalid", 32'(resp_valid), 32'h0);
    chk("single_mreg", 32'(mul_register), 32'h06);
    tick();
    @(negedge clk);
    chk("single_rvalid", 32'(resp_valid), 32'h1);
    chk("single_rdata", 32'(resp_data), 32'h04);
    chk("single_rid", 32'(resp_id), 32'h0);
    tick();
    @(negedge clk); chk("single_retire", 32'(resp_valid), 32'h0);
    tick();

    // Back-to-back from requester 1: 8*12>>>3 = 0x0C, -128*4>>>3 = 0xC0
    req_valid = 2'b10; req_reg1 = 8'h08; req_imm1 = 5'h0C;
    @(negedge clk); chk("b2b_ready0", 32'(req_ready), 32'h2);
    tick();
    req_reg1 = 8'h80; req_imm1 = 5'h04;
    @(negedge clk); chk("b2b_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("b2b_v0", 32'(resp_valid), 32'h1);
    chk("b2b_d0", 32'(resp_data), 32'h0C);
    chk("b2b_id0", 32'(resp_id), 32'h1);
    tick();
    @(negedge clk);
    chk("b2b_v1", 32'(resp_valid), 32'h1);
    chk("b2b_d1", 32'(resp_data), 32'hC0);
    chk("b2b_id1", 32'(resp_id), 32'h1);
    tick();
    @(negedge clk); chk("b2b_drain", 32'(resp_valid), 32'h0);
    tick();

    // Contention: four accepts with both requesting
`ifdef MULTI_ARB_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    req_valid = 2'b11;
    req_reg0 = 8'h10; req_imm0 = 5'h01; req_reg1 = 8'h20; req_imm1 = 5'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk($sformatf("cont_gnt%0d", i), 32'(req_ready), 32'(exp_gnt[i]));
      tick();
    end
    req_valid = 2'b00;
    tick(); tick(); tick();

    // Backpressure: 0x18*2>>>3 = 0x06, 0x40*3>>>3 = 0x18
    resp_ready = 1'b0; req_valid = 2'b11;
    req_reg0 = 8'h18; req_imm0 = 5'h02; req_reg1 = 8'h40; req_imm1 = 5'h03;
    @(negedge clk); chk("bp_acc0", 32'(req_ready), 32'h1);
    tick();
`ifdef MULTI_ARB_RR_EN
    @(negedge clk); chk("bp_acc1", 32'(req_ready), 32'h2);
`else
    @(negedge clk); chk("bp_acc1", 32'(req_ready), 32'h1);
`endif
    tick();
    @(negedge clk);
    chk("bp_full_ready", 32'(req_ready), 32'h0);
    chk("bp_hold_v", 32'(resp_valid), 32'h1);
    chk("bp_hold_d", 32'(resp_data), 32'h06);
    tick();
    @(negedge clk);
    chk("bp_full_ready2", 32'(req_ready), 32'h0);
    chk("bp_stable_d", 32'(resp_data), 32'h06);
    chk("bp_stable_id", 32'(resp_id), 32'h0);
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_drain_v", 32'(resp_valid), 32'h1);
`ifdef MULTI_ARB_RR_EN
    chk("bp_drain_d", 32'(resp_data), 32'h18);
    chk("bp_drain_id", 32'(resp_id), 32'h1);
`else
    chk("bp_drain_d", 32'(resp_data), 32'h06);
    chk("bp_drain_id", 32'(resp_id), 32'h0);
`endif
    tick();
    @(negedge clk); chk("bp_empty", 32'(resp_valid), 32'h0);
    tick();

    // Reset with both stages full
    resp_ready = 1'b0; req_valid = 2'b11;
    tick(); tick();
    n_reset = 1'b0;
    @(negedge clk); chk("mrst_ready_low", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("mrst_rvalid", 32'(resp_valid), 32'h0);
    chk("mrst_mreg", 32'(mul_register), 32'h0);
    chk("mrst_ready", 32'(req_ready), 32'h0);
    tick();
    n_reset = 1'b1; resp_ready = 1'b1;
    @(negedge clk); chk("mrst_first", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    @(negedge clk); chk("mrst_no_stale", 32'(resp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("mrst_rv", 32'(resp_valid), 32'h1);
    chk("mrst_rd", 32'(resp_data), 32'h06);
    chk("mrst_rid", 32'(resp_id), 32'h0);
    tick();

    // Idle: no requests, operands held
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk($sformatf("idle_rv%0d", i), 32'(resp_valid), 32'h0);
      tick();
    end
    chk("idle_mreg", 32'(mul_register), 32'h18);
    chk("idle_mimm", 32'(mul_immediate), 32'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_arbiter.md
Name: multi_arbiter

Overview:
- Shares one combinational `multi` unit (register × fixed-point immediate, result = (reg × imm) >>> 3, truncated) between two requesters.
- Provides a valid/ready handshake per requester, a two-stage pipeline (operand register → result register) and a tagged response channel.
- Sits between the decode/issue logic and the shared `multi` instance, which it drives through the `mul_*` ports.

Parameters:
- REG_W, 8, register/result width; matches `REG_SIZE`.
- IMM_W, 5, immediate width; matches `IMM_SIZE`.

Ports:
- clk  input  1  system clock, rising edge
- n_reset  input  1  synchronous reset, active low
- req_valid  input  2  per-requester request valid; bit i belongs to requester i
- req_ready  output  2  per-requester accept; at most one bit high per cycle
- req_reg0  input  REG_W  signed register operand, requester 0
- req_imm0  input  IMM_W  signed immediate operand, requester 0
- req_reg1  input  REG_W  signed register operand, requester 1
- req_imm1  input  IMM_W  signed immediate operand, requester 1
- mul_register  output  REG_W  operand to `multi` (registered stage 1)
- mul_immediate  output  IMM_W  operand to `multi` (registered stage 1)
- mul_result  input  REG_W  result from `multi` (combinational from `mul_*`)
- resp_valid  output  1  response valid
- resp_ready  input  1  response accept
- resp_data  output  REG_W  captured `mul_result`
- resp_id  output  1  requester index that owns `resp_data`

Behaviour:
- Reset: n_reset sampled low at a clk edge clears the following.
  - s1_valid = 0, resp_valid = 0, resp_data = 0, resp_id = 0.
  - mul_register = 0, mul_immediate = 0, s1_id = 0.
  - Round-robin pointer last = 1, so requester 0 wins first.
  - req_ready = 0 while n_reset is low.
- Reset mid-operation discards any in-flight items; no response is produced for them.
- Pipeline enable signals:
  - s2_free = !resp_valid | resp_ready.
  - s1_free = !s1_valid | s2_free.
- Grant (combinational):
  - Both requesting: requester (last ^ 1).
  - Exactly one requesting: that requester.
  - req_ready[g] = s1_free & req_valid[g] & n_reset.
  - Other bit of req_ready = 0.
- Accept, when req_valid[g] & req_ready[g] at an edge:
  - mul_register ← req_reg g, mul_immediate ← req_imm g.
  - s1_id ← g, s1_valid ← 1, last ← g.
- Stage 1 → 2, when s1_valid & s2_free at an edge:
  - resp_data ← mul_result, resp_id ← s1_id, resp_valid ← 1.
  - s1_valid ← 0 unless refilled by a same-cycle accept.
- Response: when resp_valid & resp_ready, the response retires and resp_valid drops unless stage 1 advances into it that edge.
- Latency: accept at edge N → resp_valid high after edge N+1.
- Throughput: one result per cycle while resp_ready is held high.
- Backpressure:
  - resp_valid & !resp_ready holds resp_data, resp_id and stage 1 stable.
  - With both stages full, req_ready = 0.
- Held outputs: mul_register and mul_immediate hold their value when not loading; no zeroing on drain.
- Simultaneous accept, advance and retire in one cycle are legal; there are no bubbles.
- Arithmetic is performed only by `multi`; this block never modifies operand or result bits.

Optional Feature:
- Macro: `MULTI_ARB_RR_EN`.
- Defined: round-robin grant as above; pointer `last` updates on every accept.
- Undefined: fixed priority, requester 0 always wins when both request; `last` is not implemented.
- All other behaviour, including latency and backpressure, is identical in both builds.

Test Plan:
- Single request: req0 reg = 0x06, imm = 0x06 → req_ready[0] = 1 same cycle; two cycles later resp_valid = 1, resp_data = 0x04, resp_id = 0.
- Back-to-back with resp_ready = 1:
  - req1 issues (0x08, 0x0C) then (0x80, 0x04) on consecutive cycles.
  - Responses on consecutive cycles: 0x0C then 0xC0, both with resp_id = 1.
- Contention: both requesters valid continuously for 4 accepts.
  - With `MULTI_ARB_RR_EN`: grant order 0, 1, 0, 1.
  - Without it: grant order 0, 0, 0, 0.
- Backpressure:
  - Hold resp_ready = 0 with both requests valid.
  - Exactly 2 accepts occur, then req_ready = 00; resp_data stays stable.
  - Release resp_ready → results drain in acceptance order with matching resp_id.
- Reset mid-flight:
  - Assert n_reset = 0 for one edge with both stages full.
  - Next cycle: resp_valid = 0, mul_register = 0, req_ready = 00 during reset; after release, requester 0 wins first.
- Idle: no req_valid for 10 cycles → resp_valid stays 0; mul_register and mul_immediate stay unchanged.
